// File: rtl/stream_splitter_3x8_if.sv
// Handshake bundle for the 16-bit to 3x8-bit splitter: one word input stream, three byte output streams.
interface stream_splitter_3x8_if;
  logic [15:0] data_in;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  data_1, data_2, data_3;
  logic        valid_1, valid_2, valid_3;
  logic        ready_1, ready_2, ready_3;
  logic        idle;

  modport master (
    output data_in, valid_in, ready_1, ready_2, ready_3,
    input  ready_in, data_1, data_2, data_3, valid_1, valid_2, valid_3, idle
  );

  modport slave (
    input  data_in, valid_in, ready_1, ready_2, ready_3,
    output ready_in, data_1, data_2, data_3, valid_1, valid_2, valid_3, idle
  );
endinterface

// File: rtl/stream_splitter_3x8.sv
// Splits 16-bit words into bytes dealt round-robin onto three 8-bit streams; order is fixed so no tags are needed.
module stream_splitter_3x8 #(
  parameter bit MSB_FIRST = 1'b0
) (
  input logic            clk,
  input logic            rst,
  stream_splitter_3x8_if.slave s
);
  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;

  logic [15:0]                      hold_data;
  logic [1:0]                       hold_cnt;
  logic [1:0]                       ptr;
  logic [NUM_LANES-1:0]             lane_rdy, lane_vld, lane_free, lane_sel, lane_load;
  logic [NUM_LANES-1:0][VEC_W-1:0]  lane_dat;
  logic [VEC_W-1:0]                 first_byte, second_byte, nxt_byte;
  logic                             dispatch, accept;

  assign lane_rdy    = {s.ready_3, s.ready_2, s.ready_1};
  assign lane_free   = ~lane_vld | lane_rdy;
  assign lane_sel    = NUM_LANES'(1) << ptr;
  // Only the pointed-at channel may take a byte; a stall there stalls everything.
  assign dispatch    = (hold_cnt != 2'd0) && |(lane_free & lane_sel);
  assign lane_load   = dispatch ? lane_sel : '0;

  assign first_byte  = MSB_FIRST ? hold_data[15:8] : hold_data[7:0];
  assign second_byte = MSB_FIRST ? hold_data[7:0]  : hold_data[15:8];
  assign nxt_byte    = (hold_cnt == 2'd2) ? first_byte : second_byte;

  // Accepting while the last byte leaves keeps the word stream at full rate.
  assign s.ready_in  = !rst && ((hold_cnt == 2'd0) || ((hold_cnt == 2'd1) && dispatch));
  assign accept      = s.valid_in && s.ready_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data <= '0;
      hold_cnt  <= 2'd0;
      ptr       <= 2'd0;
    end else begin
      if (dispatch) ptr <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
      if (accept) begin
        hold_data <= s.data_in;
        hold_cnt  <= 2'd2;
      end else if (dispatch) begin
        hold_cnt  <= hold_cnt - 2'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    // A load on the same edge as a drain keeps valid high and replaces the byte.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lane_dat[g] <= '0;
        lane_vld[g] <= 1'b0;
      end else if (lane_load[g]) begin
        lane_dat[g] <= nxt_byte;
        lane_vld[g] <= 1'b1;
      end else if (lane_rdy[g]) begin
        lane_vld[g] <= 1'b0;
      end
    end
  end

  assign s.data_1  = lane_dat[0];
  assign s.data_2  = lane_dat[1];
  assign s.data_3  = lane_dat[2];
  assign s.valid_1 = lane_vld[0];
  assign s.valid_2 = lane_vld[1];
  assign s.valid_3 = lane_vld[2];
  assign s.idle    = (hold_cnt == 2'd0) && !(|lane_vld);
endmodule

// File: tb/tb_stream_splitter_3x8.sv
// Bench for stream_splitter_3x8: directed scenarios plus a random stress run checked against a round-robin byte scoreboard.
`timescale 1ns/1ps
module tb_stream_splitter_3x8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_splitter_3x8_if ifa();
  stream_splitter_3x8_if ifb();

  stream_splitter_3x8 #(.MSB_FIRST(1'b0)) dut_a (.clk(clk), .rst(rst), .s(ifa));
  stream_splitter_3x8 #(.MSB_FIRST(1'b1)) dut_b (.clk(clk), .rst(rst), .s(ifb));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: per-channel queues of bytes the round-robin model says are owed.
  logic [7:0] q0[$], q1[$], q2[$];
  int         mptr = 0;
  logic [2:0] prev_stall = '0;
  logic [7:0] prev_d [3];

  function automatic int qsize(input int ch);
    case (ch)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic push(input logic [7:0] b);
    case (mptr)
      0:       q0.push_back(b);
      1:       q1.push_back(b);
      default: q2.push_back(b);
    endcase
    mptr = (mptr + 1) % 3;
  endtask

  function automatic logic [7:0] pop(input int ch);
    case (ch)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Monitor samples 1ns before each rising edge: the values the edge will act on.
  always @(negedge clk) begin
    logic [2:0] v, r;
    logic [7:0] d [3];
    #4;
    v = {ifa.valid_3, ifa.valid_2, ifa.valid_1};
    r = {ifa.ready_3, ifa.ready_2, ifa.ready_1};
    d[0] = ifa.data_1; d[1] = ifa.data_2; d[2] = ifa.data_3;
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
      mptr = 0;
      prev_stall = '0;
    end else begin
      chk("idle_vs_model", ifa.idle, (q0.size() + q1.size() + q2.size()) == 0);
      for (int k = 0; k < 3; k++) begin
        if (prev_stall[k]) begin
          chk("stall_valid", v[k], 1);
          chk("stall_data", d[k], prev_d[k]);
        end
        if (v[k] && r[k]) begin
          chk("byte_owed", qsize(k) != 0, 1);
          if (qsize(k) != 0) chk("byte_data", d[k], pop(k));
        end
        prev_stall[k] = v[k] && !r[k];
        prev_d[k] = d[k];
      end
      if (ifa.valid_in && ifa.ready_in) begin
        push(ifa.data_in[7:0]);
        push(ifa.data_in[15:8]);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic send_word(input logic [15:0] w, output int n);
    logic acc;
    ifa.data_in = w;
    ifa.valid_in = 1'b1;
    n = 0;
    do begin
      #4;
      acc = ifa.ready_in;
      n++;
      @(negedge clk);
    end while (!acc && n < 200);
    chk("accept_timeout", acc, 1);
    ifa.valid_in = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int  n, n2, n3;
    bit  done;
    ifa.data_in = '0; ifa.valid_in = 0; ifa.ready_1 = 1; ifa.ready_2 = 1; ifa.ready_3 = 1;
    ifb.data_in = '0; ifb.valid_in = 0; ifb.ready_1 = 1; ifb.ready_2 = 1; ifb.ready_3 = 1;
    repeat (3) @(negedge clk);
    chk("rst_ready_in", ifa.ready_in, 0);
    chk("rst_idle", ifa.idle, 1);
    chk("rst_valids", {ifa.valid_3, ifa.valid_2, ifa.valid_1}, 0);
    chk("rst_data", {ifa.data_3, ifa.data_2, ifa.data_1}, 0);
    chk("rst_b_ready_in", ifb.ready_in, 0);
    chk("rst_b_idle", ifb.idle, 1);

    rst = 1'b0;
    #2;
    chk("ready_in_after_rst", ifa.ready_in, 1);
    chk("b_ready_in_after_rst", ifb.ready_in, 1);
    @(negedge clk);

    // MSB-first instance: high byte first, second word continues on ch3.
    ifb.data_in = 16'hA55A; ifb.valid_in = 1;
    @(negedge clk);
    ifb.data_in = 16'h0102;
    chk("b_lat0", ifb.valid_1, 0);
    @(negedge clk);
    chk("b_ch1_v", ifb.valid_1, 1);
    chk("b_ch1_d", ifb.data_1, 8'hA5);
    chk("b_ready_in_chain", ifb.ready_in, 1);
    @(negedge clk);
    ifb.valid_in = 0;
    chk("b_ch2_v", ifb.valid_2, 1);
    chk("b_ch2_d", ifb.data_2, 8'h5A);
    chk("b_ch1_drained", ifb.valid_1, 0);
    @(negedge clk);
    chk("b_ch3_v", ifb.valid_3, 1);
    chk("b_ch3_d", ifb.data_3, 8'h01);
    @(negedge clk);
    chk("b_wrap_v", ifb.valid_1, 1);
    chk("b_wrap_d", ifb.data_1, 8'h02);
    repeat (3) @(negedge clk);
    chk("b_idle", ifb.idle, 1);

    // Back-to-back full-rate words.
    send_word(16'h1234, n);
    chk("t1_first_latency", ifa.valid_1, 0);
    send_word(16'h5678, n2);
    chk("t1_rate_w2", n2, 2);
    chk("t1_ch2_d", ifa.data_2, 8'h12);
    send_word(16'h9ABC, n3);
    chk("t1_rate_w3", n3, 2);
    repeat (6) @(negedge clk);
    chk("t1_idle", ifa.idle, 1);

    // ch2 backpressure stalls the whole rotation.
    ifa.ready_2 = 0;
    fork
      begin
        send_word(16'h1111, n); send_word(16'h2222, n); send_word(16'h3333, n);
      end
      begin
        repeat (10) @(negedge clk);
        chk("t3_ready_in_low", ifa.ready_in, 0);
        chk("t3_ch2_v", ifa.valid_2, 1);
        chk("t3_ch2_d", ifa.data_2, 8'h11);
        chk("t3_ch3_empty", ifa.valid_3, 0);
        ifa.ready_2 = 1;
      end
    join
    repeat (5) @(negedge clk);

    // Pending ch1 byte drains on the same edge its successor loads.
    ifa.ready_1 = 0;
    send_word(16'hA1B2, n);
    send_word(16'hC3D4, n);
    repeat (3) @(negedge clk);
    chk("t4_ch1_held_v", ifa.valid_1, 1);
    chk("t4_ch1_held_d", ifa.data_1, 8'hB2);
    chk("t4_ready_in_low", ifa.ready_in, 0);
    ifa.ready_1 = 1;
    @(negedge clk);
    chk("t4_reload_v", ifa.valid_1, 1);
    chk("t4_reload_d", ifa.data_1, 8'hC3);
    repeat (4) @(negedge clk);

    // Reset with one byte held and ch3 pending.
    ifa.ready_1 = 0; ifa.ready_2 = 0; ifa.ready_3 = 0;
    send_word(16'h1122, n);
    send_word(16'h3344, n);
    @(negedge clk);
    chk("t5_ch3_pending", ifa.valid_3, 1);
    chk("t5_busy", ifa.idle, 0);
    rst = 1'b1;
    #1;
    chk("t5_valids_cleared", {ifa.valid_3, ifa.valid_2, ifa.valid_1}, 0);
    chk("t5_ready_in", ifa.ready_in, 0);
    chk("t5_idle", ifa.idle, 1);
    @(negedge clk);
    ifa.ready_1 = 1; ifa.ready_2 = 1; ifa.ready_3 = 1;
    rst = 1'b0;
    @(negedge clk);
    send_word(16'hBEEF, n);
    @(negedge clk);
    chk("t5_ch1_v", ifa.valid_1, 1);
    chk("t5_ch1_d", ifa.data_1, 8'hEF);
    @(negedge clk);
    chk("t5_ch2_v", ifa.valid_2, 1);
    chk("t5_ch2_d", ifa.data_2, 8'hBE);
    repeat (3) @(negedge clk);

    // Random valid_in gaps and consumer backpressure.
    done = 0;
    fork
      begin
        for (int i = 0; i < 4000; i++) begin
          repeat ($urandom_range(0, 2)) @(negedge clk);
          send_word(16'($urandom), n);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          ifa.ready_1 = ($urandom_range(0, 3) != 0);
          ifa.ready_2 = ($urandom_range(0, 3) != 0);
          ifa.ready_3 = ($urandom_range(0, 3) != 0);
        end
      end
    join
    ifa.ready_1 = 1; ifa.ready_2 = 1; ifa.ready_3 = 1;
    repeat (10) @(negedge clk);
    chk("stress_idle", ifa.idle, 1);
    chk("stress_q_empty", q0.size() + q1.size() + q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
